// File: rtl/uart_program_loader_if.sv
// Memory write port between the UART program loader and the CPU's BRAM.
// The loader drives all three signals; the memory only observes them.
interface uart_program_loader_if;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_en;

    modport master (
        output mem_address,
        output mem_write_data,
        output mem_write_en
    );

    modport slave (
        input mem_address,
        input mem_write_data,
        input mem_write_en
    );
endinterface

// File: rtl/uart_program_loader.sv
// Serial boot loader: receives a length-prefixed image over an 8N1 UART,
// packs little-endian 32-bit words, writes them into program memory and
// keeps the CPU in reset until a complete, well-formed image has landed.
// CLK_FREQ_HZ / BAUD must be at least 4 clocks per bit.
module uart_program_loader #(
    parameter int CLK_FREQ_HZ  = 100000000,
    parameter int BAUD         = 115200,
    parameter int NUM_OF_BYTES = 800
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RxD,
    input  logic                  start,
    uart_program_loader_if.master mem,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error
);

    localparam int          CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam logic [31:0] BIT_LAST     = 32'(CLKS_PER_BIT - 1);
    localparam logic [31:0] HALF_LAST    = 32'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0] MAX_LEN      = 32'(NUM_OF_BYTES);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [2:0] {
        L_IDLE,
        L_LEN,
        L_DATA,
        L_DONE,
        L_ERROR
    } ld_state_e;

    // A length is unusable if empty, larger than memory, or not whole words.
    function automatic logic len_is_bad(input logic [31:0] len);
        return (len == 32'd0) || (len > MAX_LEN) || (len[1:0] != 2'b00);
    endfunction

    // ---------------- RxD synchronizer ----------------
    logic rxd_meta_q;
    logic rxd_sync_q;
    logic rxd_prev_q;

    // Two-flop synchronizer plus a history flop used to spot falling edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= RxD;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    // ---------------- RX bit engine ----------------
    rx_state_e   rx_state_q, rx_state_d;
    logic [31:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        byte_valid_q, byte_valid_d;
    logic        frame_err_q, frame_err_d;

    // RX engine state, bit timer, shift register and one-cycle result pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= 32'd0;
            rx_bit_q     <= 3'd0;
            rx_shift_q   <= 8'd0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // RX next state: half-bit start check, eight LSB-first data samples, stop check.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = 32'd0;
                rx_bit_d = 3'd0;
                if (rxd_prev_q && !rxd_sync_q) begin
                    rx_state_d = RX_START;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = 32'd0;
                    // Line already back high mid start bit: a glitch, not a frame.
                    if (rxd_sync_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 32'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = 32'd0;
                    rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_state_d = RX_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 32'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = 32'd0;
                    rx_state_d = RX_IDLE;
                    if (rxd_sync_q) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 32'd1;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
                rx_cnt_d   = 32'd0;
                rx_bit_d   = 3'd0;
            end
        endcase
    end

    // ---------------- Loader FSM ----------------
    ld_state_e   ld_state_q, ld_state_d;
    logic [31:0] byte_cnt_q, byte_cnt_d;
    logic [31:0] len_q, len_d;
    logic [31:0] word_q, word_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_write_data_q, mem_write_data_d;
    logic        mem_write_en_q, mem_write_en_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        load_done_q, load_done_d;
    logic        load_error_q, load_error_d;

    // Bytes arrive LSB-first, so shifting in from the top leaves little-endian order.
    logic [31:0] new_len_s;
    logic [31:0] new_word_s;
    assign new_len_s  = {rx_shift_q, len_q[31:8]};
    assign new_word_s = {rx_shift_q, word_q[31:8]};

    // Loader state, counters and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_state_q       <= L_IDLE;
            byte_cnt_q       <= 32'd0;
            len_q            <= 32'd0;
            word_q           <= 32'd0;
            mem_address_q    <= 32'd0;
            mem_write_data_q <= 32'd0;
            mem_write_en_q   <= 1'b0;
            cpu_hold_q       <= 1'b0;
            load_done_q      <= 1'b0;
            load_error_q     <= 1'b0;
        end else begin
            ld_state_q       <= ld_state_d;
            byte_cnt_q       <= byte_cnt_d;
            len_q            <= len_d;
            word_q           <= word_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            mem_write_en_q   <= mem_write_en_d;
            cpu_hold_q       <= cpu_hold_d;
            load_done_q      <= load_done_d;
            load_error_q     <= load_error_d;
        end
    end

    // Loader next state: arm, collect length, pack and write words, finish or abort.
    always_comb begin
        ld_state_d       = ld_state_q;
        byte_cnt_d       = byte_cnt_q;
        len_d            = len_q;
        word_d           = word_q;
        mem_write_data_d = mem_write_data_q;
        mem_write_en_d   = 1'b0;
        cpu_hold_d       = cpu_hold_q;
        load_done_d      = load_done_q;
        load_error_d     = load_error_q;
        // The address stays on the written word during the strobe, then steps on.
        if (mem_write_en_q) begin
            mem_address_d = mem_address_q + 32'd4;
        end else begin
            mem_address_d = mem_address_q;
        end
        case (ld_state_q)
            L_IDLE, L_DONE, L_ERROR: begin
                // Received bytes are ignored here; only start matters.
                if (start) begin
                    ld_state_d    = L_LEN;
                    cpu_hold_d    = 1'b1;
                    load_done_d   = 1'b0;
                    load_error_d  = 1'b0;
                    byte_cnt_d    = 32'd0;
                    len_d         = 32'd0;
                    word_d        = 32'd0;
                    mem_address_d = 32'd0;
                end else begin
                    ld_state_d = ld_state_q;
                end
            end
            L_LEN: begin
                if (frame_err_q) begin
                    ld_state_d   = L_ERROR;
                    load_error_d = 1'b1;
                end else if (byte_valid_q) begin
                    len_d = new_len_s;
                    if (byte_cnt_q == 32'd3) begin
                        byte_cnt_d = 32'd0;
                        if (len_is_bad(new_len_s)) begin
                            ld_state_d   = L_ERROR;
                            load_error_d = 1'b1;
                        end else begin
                            ld_state_d = L_DATA;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 32'd1;
                    end
                end else begin
                    ld_state_d = L_LEN;
                end
            end
            L_DATA: begin
                if (frame_err_q) begin
                    // The partially assembled word is dropped and never written.
                    ld_state_d   = L_ERROR;
                    load_error_d = 1'b1;
                end else if (byte_valid_q) begin
                    word_d     = new_word_s;
                    byte_cnt_d = byte_cnt_q + 32'd1;
                    if (byte_cnt_q[1:0] == 2'd3) begin
                        mem_write_data_d = new_word_s;
                        mem_write_en_d   = 1'b1;
                    end else begin
                        mem_write_en_d = 1'b0;
                    end
                end else if (mem_write_en_q && (byte_cnt_q == len_q)) begin
                    // Final word is being written this cycle: release the CPU.
                    ld_state_d  = L_DONE;
                    cpu_hold_d  = 1'b0;
                    load_done_d = 1'b1;
                end else begin
                    ld_state_d = L_DATA;
                end
            end
            default: begin
                ld_state_d = L_IDLE;
                cpu_hold_d = 1'b0;
            end
        endcase
    end

    assign mem.mem_address    = mem_address_q;
    assign mem.mem_write_data = mem_write_data_q;
    assign mem.mem_write_en   = mem_write_en_q;
    assign cpu_hold           = cpu_hold_q;
    assign load_done          = load_done_q;
    assign load_error         = load_error_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader: serial images are built in the
// bench, expected writes and flag levels come from the image format rules.
module tb_uart_program_loader;

    localparam int CPB = 10;

    logic clk = 1'b0;
    logic reset;
    logic RxD;
    logic start;
    logic cpu_hold;
    logic load_done;
    logic load_error;

    uart_program_loader_if mem_if();

    uart_program_loader #(
        .CLK_FREQ_HZ (1000000),
        .BAUD        (100000),
        .NUM_OF_BYTES(800)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .RxD       (RxD),
        .start     (start),
        .mem       (mem_if),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_error(load_error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    bit chk_en   = 1'b0;
    bit exp_hold = 1'b0;
    bit exp_done = 1'b0;
    bit exp_err  = 1'b0;

    logic [31:0] exp_wa[$];
    logic [31:0] exp_wd[$];
    int          exp_lo[$];
    int          exp_hi[$];
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic [7:0]  img_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Send one 8N1 frame; if wr is set, the frame completes a word to be written.
    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit wr,
                             input logic [31:0] wa, input logic [31:0] wd);
        @(negedge clk);
        RxD = 1'b0;
        if (wr) begin
            exp_wa.push_back(wa);
            exp_wd.push_back(wd);
            exp_lo.push_back(cyc + 92);
            exp_hi.push_back(cyc + 104);
        end
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            repeat (CPB) @(negedge clk);
        end
        RxD = stop_ok;
        repeat (CPB) @(negedge clk);
        RxD = 1'b1;
        repeat ($urandom_range(0, 15)) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        chk_en = 1'b0;
        start  = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        exp_hold = 1'b1;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        chk_en   = 1'b1;
    endtask

    // Start pulse that must be ignored (loader busy): expectations unchanged.
    task automatic raw_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Stream img_q; the model derives writes and the final outcome from the image.
    task automatic run_image(input int bad_idx, input int start_at);
        logic [31:0] len;
        logic [31:0] wa;
        logic [31:0] wd;
        bit          wr;
        bit          end_ok;
        bit          end_err;
        bit          stop_ok;
        len = 32'd0;
        for (int i = 0; i < img_q.size(); i++) begin
            wr      = 1'b0;
            wa      = 32'd0;
            wd      = 32'd0;
            end_ok  = 1'b0;
            end_err = 1'b0;
            stop_ok = (i != bad_idx);
            if (i < 4) len[8*i +: 8] = img_q[i];
            if (!stop_ok) begin
                end_err = 1'b1;
            end else if (i == 3) begin
                if (len == 32'd0 || len > 32'd800 || len % 32'd4 != 32'd0) end_err = 1'b1;
            end else if (i >= 4) begin
                if ((i - 4) % 4 == 3) begin
                    wr = 1'b1;
                    wa = 32'(i - 7);
                    wd = {img_q[i], img_q[i-1], img_q[i-2], img_q[i-3]};
                end
                if (32'(i - 3) == len) end_ok = 1'b1;
            end
            if (i == start_at) raw_start();
            if (end_ok || end_err) chk_en = 1'b0;
            send_byte(img_q[i], stop_ok, wr, wa, wd);
            if (end_ok || end_err) begin
                repeat (4) @(negedge clk);
                exp_hold = end_err;
                exp_done = end_ok;
                exp_err  = end_err;
                chk_en   = 1'b1;
                break;
            end
        end
    endtask

    task automatic push_len(input logic [31:0] l);
        for (int i = 0; i < 4; i++) img_q.push_back(l[8*i +: 8]);
    endtask

    initial begin
        int base;
        reset = 1'b0;
        RxD   = 1'b1;
        start = 1'b0;
        fork
            begin : compare
                logic [31:0] wa;
                logic [31:0] wd;
                int          lo;
                int          hi;
                forever begin
                    @(posedge clk);
                    cyc++;
                    #1;
                    if (chk_en) begin
                        tests++;
                        if (cpu_hold !== exp_hold || load_done !== exp_done || load_error !== exp_err) begin
                            fails++;
                            $display("FAIL flags @%0d: hold/done/err got %b%b%b, expected %b%b%b",
                                     cyc, cpu_hold, load_done, load_error, exp_hold, exp_done, exp_err);
                        end
                    end
                    if (mem_if.mem_write_en === 1'b1) begin
                        obs_addr.push_back(mem_if.mem_address);
                        obs_data.push_back(mem_if.mem_write_data);
                        tests++;
                        if (exp_wa.size() == 0) begin
                            fails++;
                            $display("FAIL unexpected_write @%0d: addr %h data %h, expected no write",
                                     cyc, mem_if.mem_address, mem_if.mem_write_data);
                        end else begin
                            wa = exp_wa.pop_front();
                            wd = exp_wd.pop_front();
                            lo = exp_lo.pop_front();
                            hi = exp_hi.pop_front();
                            if (mem_if.mem_address !== wa || mem_if.mem_write_data !== wd || cyc < lo || cyc > hi) begin
                                fails++;
                                $display("FAIL write @%0d: addr %h data %h, expected addr %h data %h in cycles %0d..%0d",
                                         cyc, mem_if.mem_address, mem_if.mem_write_data, wa, wd, lo, hi);
                            end
                        end
                    end else if (exp_wa.size() != 0 && cyc > exp_hi[0]) begin
                        tests++;
                        fails++;
                        $display("FAIL missing_write @%0d: no strobe, expected addr %h data %h",
                                 cyc, exp_wa[0], exp_wd[0]);
                        wa = exp_wa.pop_front();
                        wd = exp_wd.pop_front();
                        lo = exp_lo.pop_front();
                        hi = exp_hi.pop_front();
                    end
                end
            end
            begin : stimulus
                // Reset state.
                repeat (3) @(negedge clk);
                check("rst_addr", mem_if.mem_address, 32'd0);
                check("rst_data", mem_if.mem_write_data, 32'd0);
                check("rst_flags", {28'd0, mem_if.mem_write_en, cpu_hold, load_done, load_error}, 32'd0);
                reset  = 1'b1;
                chk_en = 1'b1;
                repeat (1000) @(negedge clk);
                check("idle_no_write", 32'(obs_addr.size()), 32'd0);

                // Two-word image.
                img_q = '{8'h08, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                          8'h78, 8'h56, 8'h34, 8'h12};
                pulse_start();
                run_image(-1, -1);
                check("img2_count", 32'(obs_addr.size()), 32'd2);
                check("img2_w0", obs_data[0], 32'hDEADBEEF);
                check("img2_a0", obs_addr[0], 32'd0);
                check("img2_w1", obs_data[1], 32'h12345678);
                check("img2_a1", obs_addr[1], 32'd4);
                check("img2_done", {30'd0, cpu_hold, load_done}, 32'd1);

                // Misaligned and oversize lengths.
                base  = obs_addr.size();
                img_q = '{8'h06, 8'h00, 8'h00, 8'h00};
                pulse_start();
                run_image(-1, -1);
                check("len6_err", {30'd0, cpu_hold, load_error}, 32'd3);
                img_q = '{8'h24, 8'h03, 8'h00, 8'h00};
                pulse_start();
                run_image(-1, -1);
                check("len804_err", {30'd0, cpu_hold, load_error}, 32'd3);
                check("len_err_nowrite", 32'(obs_addr.size()), 32'(base));

                // Framing error in data, then a good reload.
                img_q = '{8'h04, 8'h00, 8'h00, 8'h00, 8'hAA};
                pulse_start();
                run_image(4, -1);
                check("frame_err", {30'd0, cpu_hold, load_error}, 32'd3);
                img_q = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
                pulse_start();
                run_image(-1, -1);
                check("reload_word", obs_data[obs_data.size()-1], 32'h44332211);
                check("reload_flags", {29'd0, cpu_hold, load_done, load_error}, 32'd2);

                // Short glitch while collecting the length.
                pulse_start();
                @(negedge clk);
                RxD = 1'b0;
                repeat (3) @(negedge clk);
                RxD = 1'b1;
                repeat (40) @(negedge clk);
                img_q = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h5A, 8'hA5, 8'hC3, 8'h3C};
                run_image(-1, -1);
                check("glitch_word", obs_data[obs_data.size()-1], 32'h3CC3A55A);
                check("glitch_addr", obs_addr[obs_addr.size()-1], 32'd0);

                // Random valid images, with an ignored start pulse mid-image.
                for (int r = 0; r < 4; r++) begin
                    int l;
                    l = 4 * $urandom_range(1, 10);
                    img_q = {};
                    push_len(32'(l));
                    for (int k = 0; k < l; k++) img_q.push_back(8'($urandom));
                    pulse_start();
                    run_image(-1, $urandom_range(1, l + 2));
                end

                // Random bad lengths.
                for (int r = 0; r < 3; r++) begin
                    logic [31:0] l;
                    if (r == 0) l = 32'($urandom_range(1, 199)) * 32'd4 + 32'($urandom_range(1, 3));
                    else if (r == 1) l = 32'd800 + 32'd4 * 32'($urandom_range(1, 50));
                    else l = 32'd0;
                    img_q = {};
                    push_len(l);
                    pulse_start();
                    run_image(-1, -1);
                end

                // Maximum length accepted; reset one byte past a word boundary.
                img_q = '{8'h20, 8'h03, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
                pulse_start();
                run_image(-1, -1);
                check("len800_word", obs_data[obs_data.size()-1], 32'h04030201);
                check("len800_busy", {29'd0, cpu_hold, load_done, load_error}, 32'd4);
                base   = obs_addr.size();
                chk_en = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                #1;
                check("mid_rst_addr", mem_if.mem_address, 32'd0);
                check("mid_rst_data", mem_if.mem_write_data, 32'd0);
                check("mid_rst_flags", {28'd0, mem_if.mem_write_en, cpu_hold, load_done, load_error}, 32'd0);
                repeat (3) @(negedge clk);
                reset    = 1'b1;
                exp_hold = 1'b0;
                exp_done = 1'b0;
                exp_err  = 1'b0;
                chk_en   = 1'b1;
                send_byte(8'h06, 1'b1, 1'b0, 32'd0, 32'd0);
                send_byte(8'h07, 1'b1, 1'b0, 32'd0, 32'd0);
                send_byte(8'h08, 1'b1, 1'b0, 32'd0, 32'd0);
                repeat (50) @(negedge clk);
                check("post_rst_nowrite", 32'(obs_addr.size()), 32'(base));
                check("pending_writes", 32'(exp_wa.size()), 32'd0);
            end
            begin : watchdog
                #900000;
                fails++;
                $display("FAIL watchdog: simulation time limit reached, expected completion");
            end
        join_any
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
